// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: types and defaults shared by prod_accum and its users.
//   state_t    - controller states (IDLE, ACCUM, DONE)
//   N_DEF      - default multiplier operand width
//   acc_w_def  - default accumulator width for a given operand width
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_DEF = 8;

  // Eight guard bits above the full product width.
  function automatic int acc_w_def(input int n);
    return 2 * n + 8;
  endfunction

  localparam int ACC_W_DEF = acc_w_def(N_DEF);

endpackage

// File: rtl/prod_accum.sv
// prod_accum: sums a run of unsigned products from an upstream multiplier.
// A start request latches the run length, products are taken over a
// valid/ready handshake, and the sum is offered over a second handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request to begin a run (honoured only in IDLE)
//   len        in   [7:0] products in the run, sampled with start
//   p          in   [2*N-1:0] unsigned product
//   p_valid    in   p is valid this cycle
//   p_ready    out  block takes p this cycle (ACCUM only)
//   res        out  [ACC_W-1:0] accumulated sum, straight from the register
//   res_valid  out  res is valid (DONE)
//   res_ready  in   downstream takes res
//   ovf        out  sticky carry-out of the accumulator for this run
//   busy       out  not IDLE
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; outputs of the previous run stay visible
// ACCUM | taking products until the remaining count reaches zero
// DONE  | res/ovf held and res_valid high until res_ready
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int ACC_W = acc_w_def(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         len,
  input  logic [2*N-1:0]     p,
  input  logic               p_valid,
  output logic               p_ready,
  output logic [ACC_W-1:0]   res,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               ovf,
  output logic               busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic               w_accept;
  logic               w_xfer;
  logic [ACC_W:0]     w_sum;

  assign w_accept = (r_state == IDLE) && start;
  assign w_xfer   = (r_state == ACCUM) && p_valid;

  // One extra bit on the left catches the carry out of the accumulator.
  assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - 2 * N){1'b0}}, p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == 8'd0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_xfer && (r_cnt == 8'd1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (w_accept) begin
      r_cnt <= len;
    end else if (w_xfer) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= r_ovf | w_sum[ACC_W];
    end
  end

  // Handshake outputs decode the state only, so p_ready never sees p_valid.
  assign p_ready   = (r_state == ACCUM);
  assign res_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign res       = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_prod_accum.sv
// Two instances share all stimulus: the default width (ACC_W=24) and a
// narrow one (ACC_W=16) that exposes wrap-around and the sticky carry.
// Expected results are queued per instance when a run is issued; a monitor
// pops and compares whenever an instance completes its result handshake.
module tb_prod_accum;
  import prod_accum_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [15:0] p = 16'd0;
  logic        p_valid = 1'b0;
  logic        res_ready = 1'b1;

  logic        p_ready24, res_valid24, ovf24, busy24;
  logic [23:0] res24;
  logic        p_ready16, res_valid16, ovf16, busy16;
  logic [15:0] res16;

  exp_t q24[$];
  exp_t q16[$];
  exp_t m_e24, m_e16;

  int n_checks = 0;
  int n_pass   = 0;

  prod_accum dut24 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .p(p),
    .p_valid(p_valid), .p_ready(p_ready24), .res(res24),
    .res_valid(res_valid24), .res_ready(res_ready), .ovf(ovf24),
    .busy(busy24)
  );

  prod_accum #(.N(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .p(p),
    .p_valid(p_valid), .p_ready(p_ready16), .res(res16),
    .res_valid(res_valid16), .res_ready(res_ready), .ovf(ovf16),
    .busy(busy16)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] r24, input logic o24,
                      input logic [63:0] r16, input logic o16);
    q24.push_back('{res: r24, ovf: o24});
    q16.push_back('{res: r16, ovf: o16});
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Offer one product and hold it until the edge that takes it.
  task automatic send(input logic [15:0] v);
    int budget;
    budget  = 20;
    p       = v;
    p_valid = 1'b1;
    while (!p_ready24 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      $display("FAIL p_ready wait: got timeout, expected p_ready");
    end
    tick();
    p_valid = 1'b0;
  endtask

  // Result monitor.
  always @(negedge clk) begin
    if (rst_n && res_valid24 && res_ready) begin
      if (q24.size() == 0) begin
        n_checks++;
        $display("FAIL dut24 unexpected result: got %0d, expected none", res24);
      end else begin
        m_e24 = q24.pop_front();
        check("dut24 res", 64'(res24), m_e24.res);
        check("dut24 ovf", 64'(ovf24), 64'(m_e24.ovf));
      end
    end
    if (rst_n && res_valid16 && res_ready) begin
      if (q16.size() == 0) begin
        n_checks++;
        $display("FAIL dut16 unexpected result: got %0d, expected none", res16);
      end else begin
        m_e16 = q16.pop_front();
        check("dut16 res", 64'(res16), m_e16.res);
        check("dut16 ovf", 64'(ovf16), 64'(m_e16.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst res", 64'(res24), 0);
    check("rst res_valid", 64'(res_valid24), 0);
    check("rst p_ready", 64'(p_ready24), 0);
    check("rst busy", 64'(busy24), 0);
    check("rst ovf", 64'(ovf24), 0);
    rst_n = 1'b1;

    // len=3: 21+108+100
    push(229, 0, 229, 0);
    do_start(8'd3);
    check("accum busy", 64'(busy24), 1);
    send(16'd21);
    send(16'd108);
    check("no early res_valid", 64'(res_valid24), 0);
    send(16'd100);
    check("res_valid after last", 64'(res_valid24), 1);
    check("res_valid16 after last", 64'(res_valid16), 1);
    tick();
    check("back to idle", 64'(busy24), 0);

    // len=0
    push(0, 0, 0, 0);
    check("len0 p_ready before", 64'(p_ready24), 0);
    do_start(8'd0);
    check("len0 res_valid", 64'(res_valid24), 1);
    check("len0 res", 64'(res24), 0);
    check("len0 p_ready", 64'(p_ready24), 0);
    tick();

    // Gaps and downstream stall
    res_ready = 1'b0;
    push(16390, 0, 16390, 0);
    do_start(8'd2);
    send(16'd6);
    for (int i = 0; i < 3; i++) begin
      check("gap acc", 64'(res24), 6);
      check("gap p_ready", 64'(p_ready24), 1);
      tick();
    end
    send(16'd16384);
    for (int i = 0; i < 5; i++) begin
      check("stall res", 64'(res24), 16390);
      check("stall res_valid", 64'(res_valid24), 1);
      check("stall busy", 64'(busy24), 1);
      tick();
    end
    res_ready = 1'b1;
    tick();

    // Wrap and sticky carry in the narrow instance, then cleared by start
    push(130050, 0, 64514, 1);
    do_start(8'd2);
    send(16'd65025);
    send(16'd65025);
    check("ovf16 in DONE", 64'(ovf16), 1);
    tick();
    push(5, 0, 5, 0);
    do_start(8'd1);
    check("ovf16 cleared", 64'(ovf16), 0);
    send(16'd5);
    tick();

    // Reset mid-run
    do_start(8'd4);
    send(16'd1);
    send(16'd2);
    check("pre-reset acc", 64'(res24), 3);
    rst_n = 1'b0;
    #1;
    check("async rst res", 64'(res24), 0);
    check("async rst busy", 64'(busy24), 0);
    check("async rst p_ready", 64'(p_ready24), 0);
    check("async rst res_valid", 64'(res_valid24), 0);
    check("async rst ovf", 64'(ovf24), 0);
    tick();
    tick();
    rst_n = 1'b1;
    push(7, 0, 7, 0);
    do_start(8'd1);
    check("first start after rst", 64'(busy24), 1);
    send(16'd7);
    tick();

    // Start ignored in ACCUM
    push(30, 0, 30, 0);
    do_start(8'd2);
    send(16'd10);
    do_start(8'd9);
    check("ignored start busy", 64'(p_ready24), 1);
    send(16'd20);
    check("ignored start done", 64'(res_valid24), 1);
    tick();

    tick();
    tick();
    check("q24 drained", 64'(q24.size()), 0);
    check("q16 drained", 64'(q16.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N SHALL default to 8 and is the multiplier operand width.
REQ-003 Parameter ACC_W SHALL default to 2*N+8 and is the accumulator width; legal range is 2*N to 2*N+16.
REQ-004 Port clk SHALL be an input, width 1: rising-edge clock.
REQ-005 Port rst_n SHALL be an input, width 1: asynchronous active-low reset.
REQ-006 Port start SHALL be an input, width 1: single-cycle request to begin a new accumulation.
REQ-007 Port len SHALL be an input, width 8: number of products to accumulate, sampled when start is accepted.
REQ-008 Port p SHALL be an input, width 2*N: unsigned product from the upstream multiplier.
REQ-009 Port p_valid SHALL be an input, width 1: p is valid this cycle.
REQ-010 Port p_ready SHALL be an output, width 1: block accepts p this cycle.
REQ-011 Port res SHALL be an output, width ACC_W: accumulated sum.
REQ-012 Port res_valid SHALL be an output, width 1: res is valid.
REQ-013 Port res_ready SHALL be an input, width 1: downstream consumes res.
REQ-014 Port ovf SHALL be an output, width 1: sticky carry-out of the accumulator for the current result.
REQ-015 Port busy SHALL be an output, width 1: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE with start=1 and len!=0, the block SHALL latch len into a remaining-count register, clear acc and ovf, and move to ACCUM on the next edge.
REQ-018 In IDLE with start=1 and len==0, the block SHALL clear acc and ovf and move directly to DONE, giving res=0 with res_valid high one cycle after start.
REQ-019 start SHALL be ignored in ACCUM and DONE.
REQ-020 p_ready SHALL be 1 only in ACCUM and SHALL NOT depend combinationally on p_valid.
REQ-021 A transfer SHALL occur on each edge where p_valid and p_ready are both 1: acc <= acc + zero-extended p, and the count decrements by 1.
REQ-022 Idle cycles with p_valid=0 SHALL leave acc and the count unchanged; gaps are unlimited.
REQ-023 acc SHALL wrap modulo 2^ACC_W.
REQ-024 ovf SHALL be set on any transfer that produces a carry out of bit ACC_W-1, and SHALL then stay set until the next start is accepted.
REQ-025 When the transfer with count==1 occurs, the FSM SHALL enter DONE on that edge, so res_valid rises one cycle after the last product is accepted.
REQ-026 In DONE, res_valid SHALL be 1, and res and ovf SHALL be held stable until res_ready=1.
REQ-027 In DONE, res_ready=1 SHALL complete the handshake and return the FSM to IDLE on the next edge.
REQ-028 After DONE, a start SHALL be accepted in the IDLE cycle that follows; no back-to-back start is accepted from DONE.
REQ-029 res SHALL be driven directly from the acc register, with no combinational path from p to res.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force state=IDLE, acc=0, count=0, ovf=0, res_valid=0, p_ready=0 and busy=0, regardless of clock.
REQ-031 Reset during ACCUM or DONE SHALL abort the operation; any partial sum SHALL be discarded and no res_valid is produced.
REQ-032 The first start SHALL be accepted on the first rising edge after rst_n is deasserted.

Structure
REQ-033 A shared package prod_accum_pkg SHALL hold the state enum (IDLE, ACCUM, DONE), the default N, and the default ACC_W expression.
REQ-034 The block SHALL be a single module with no sub-module; the FSM, counter and accumulator are each a few always blocks.
REQ-035 The RTL SHALL be synthesizable, with no latches and a single always_ff per register group, all using the asynchronous reset.

Verification
REQ-036 Scenario: start with len=3, then p=21, 108, 100 with no gaps -> res=229, ovf=0, res_valid high exactly one cycle after the third transfer.
REQ-037 Scenario: start with len=0 -> res_valid=1 and res=0 on the next cycle, and p_ready stays 0 throughout.
REQ-038 Scenario: len=2, p=6, then 3 gap cycles, then p=16384 -> res=16390; also hold res_ready=0 for 5 cycles -> res and res_valid stay stable and busy=1.
REQ-039 Scenario: with ACC_W=16, len=2, p=65025 and 65025 -> res=64514 and ovf=1; a following start with len=1 and p=5 -> res=5 and ovf=0.
REQ-040 Scenario: with len=4, pull rst_n low after 2 transfers -> all outputs go to 0 immediately; after release, start with len=1 and p=7 -> res=7.
REQ-041 Scenario: pulse start during ACCUM with len=9 -> it is ignored, the original len of 2 completes, and the result equals the sum of those 2 products.
